// File: rtl/i2s_master_rx_ctrl.sv
// I2S master-mode receiver: generates sck/ws from clk, deserialises sd_i into
// stereo frames and hands them downstream on a valid/ready handshake.
module i2s_master_rx_ctrl #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 sd_i,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic [WORD_BITS-1:0] out_left,
  output logic [WORD_BITS-1:0] out_right,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy_o,
  output logic                 ovr_o,
  input  logic                 ovr_clr_i
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned K_W   = $clog2(2 * WORD_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [K_W-1:0]   K_LEFT   = K_W'(WORD_BITS - 1);
  localparam logic [K_W-1:0]   K_WS_HI  = K_W'(2 * WORD_BITS - 2);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] left_hold_q, left_hold_d;
  logic [WORD_BITS-1:0] out_left_q, out_left_d;
  logic [WORD_BITS-1:0] out_right_q, out_right_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 left_cap_q, left_cap_d;
  logic                 frame_done_q, frame_done_d;

  logic tick_c;
  logic rise_c;
  logic fall_c;
  logic ovr_set_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      k_q          <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
      left_cap_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      k_q          <= k_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      busy_q       <= busy_d;
      left_cap_q   <= left_cap_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sck_d        = sck_q;
    ws_d         = ws_q;
    k_d          = k_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    out_left_d   = out_left_q;
    out_right_d  = out_right_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;
    ovr_set_c    = 1'b0;

    tick_c = (state_q != IDLE) && (div_q == DIV_LAST);
    rise_c = tick_c && !sck_q;
    fall_c = tick_c && sck_q;

    // Bit-clock generation, sampling and slot sequencing
    case (state_q)
      IDLE: begin
        div_d = '0;
        sck_d = 1'b0;
        ws_d  = 1'b0;
        if (en_i) begin
          state_d = RUN;
          k_d     = '0;
          shift_d = '0;
        end
      end
      default: begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          sck_d = !sck_q;
        end
        if (rise_c) begin
          shift_d = {shift_q[WORD_BITS-2:0], sd_i};
          k_d     = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
        end
        if (fall_c) begin
          ws_d = (k_q >= K_LEFT) && (k_q <= K_WS_HI);
        end
        // k_q == 0 on a fall means the last rise of a frame has just happened
        if (fall_c && (k_q == '0) && (state_q == STOP || !en_i)) begin
          state_d = IDLE;
        end else if (state_q == RUN && !en_i) begin
          state_d = STOP;
        end
      end
    endcase

    left_cap_d   = rise_c && (k_q == K_LEFT);
    frame_done_d = rise_c && (k_q == K_LAST);

    // Capture one cycle after the sampling rise, when shift_q holds the full word
    if (left_cap_q) begin
      left_hold_d = shift_q;
    end

    if (frame_done_q) begin
      if (!valid_q || out_ready) begin
        out_left_d  = left_hold_q;
        out_right_d = shift_q;
        valid_d     = 1'b1;
      end else begin
        ovr_set_c = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (ovr_set_c) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign sck_o     = sck_q;
  assign ws_o      = ws_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = valid_q;
  assign busy_o    = busy_q;
  assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_i2s_master_rx_ctrl.sv
// Directed bench for i2s_master_rx_ctrl: a DIV=2/32-bit instance and a
// DIV=3/16-bit instance fed by a codec model that drives sd_i on sck falls.
module tb_i2s_master_rx_ctrl;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: DIV=2, WORD_BITS=32
  logic        a_en, a_sd, a_sck, a_ws, a_valid, a_ready, a_busy, a_ovr, a_clr;
  logic [31:0] a_left, a_right;
  // Instance B: DIV=3, WORD_BITS=16
  logic        b_en, b_sd, b_sck, b_ws, b_valid, b_ready, b_busy, b_ovr, b_clr;
  logic [15:0] b_left, b_right;

  i2s_master_rx_ctrl #(.DIV(2), .WORD_BITS(32)) u_a (
    .clk(clk), .rst(rst), .en_i(a_en), .sd_i(a_sd), .sck_o(a_sck), .ws_o(a_ws),
    .out_left(a_left), .out_right(a_right), .out_valid(a_valid), .out_ready(a_ready),
    .busy_o(a_busy), .ovr_o(a_ovr), .ovr_clr_i(a_clr)
  );

  i2s_master_rx_ctrl #(.DIV(3), .WORD_BITS(16)) u_b (
    .clk(clk), .rst(rst), .en_i(b_en), .sd_i(b_sd), .sck_o(b_sck), .ws_o(b_ws),
    .out_left(b_left), .out_right(b_right), .out_valid(b_valid), .out_ready(b_ready),
    .busy_o(b_busy), .ovr_o(b_ovr), .ovr_clr_i(b_clr)
  );

  vec_t a_tbl[8];
  vec_t b_tbl[2];

  int   a_base = 0, a_off = 0, b_base = 0, b_off = 0;
  bit   a_kick = 1'b0, b_kick = 1'b0;
  int   a_bc = 0, b_bc = 0, a_ws_err = 0, b_ws_err = 0, a_ws_n = 0, b_ws_n = 0;
  logic a_sck_prev = 1'b0, b_sck_prev = 1'b0;

  function automatic logic a_bit(int rel);
    int f = rel / 64;
    int k = rel % 64;
    vec_t v = a_tbl[(a_base + f) % 8];
    return (k < 32) ? v.l[31 - k] : v.r[63 - k];
  endfunction

  function automatic logic b_bit(int rel);
    int f = rel / 32;
    int k = rel % 32;
    vec_t v = b_tbl[(b_base + f) % 2];
    return (k < 16) ? v.l[15 - k] : v.r[31 - k];
  endfunction

  // Codec model A: count rises, check ws at each rise, present next bit on fall
  always @(a_sck or a_kick) begin
    if (a_sck === 1'b1 && a_sck_prev === 1'b0) begin
      if (a_ws !== ((((a_bc - a_off) % 64) >= 31) && (((a_bc - a_off) % 64) <= 62)))
        a_ws_err = a_ws_err + 1;
      a_ws_n = a_ws_n + 1;
      a_bc   = a_bc + 1;
    end
    a_sck_prev = a_sck;
    if (a_sck !== 1'b1) a_sd = a_bit(a_bc - a_off);
  end

  always @(b_sck or b_kick) begin
    if (b_sck === 1'b1 && b_sck_prev === 1'b0) begin
      if (b_ws !== ((((b_bc - b_off) % 32) >= 15) && (((b_bc - b_off) % 32) <= 30)))
        b_ws_err = b_ws_err + 1;
      b_ws_n = b_ws_n + 1;
      b_bc   = b_bc + 1;
    end
    b_sck_prev = b_sck;
    if (b_sck !== 1'b1) b_sd = b_bit(b_bc - b_off);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp = n_cmp + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic a_start(input int base);
    a_base = base;
    a_off  = a_bc;
    a_kick = !a_kick;
    a_en   = 1'b1;
  endtask

  task automatic b_start(input int base);
    b_base = base;
    b_off  = b_bc;
    b_kick = !b_kick;
    b_en   = 1'b1;
  endtask

  task automatic a_wait_valid(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!a_valid && cyc < 2000);
    if (!a_valid) timeout("a_wait_valid");
  endtask

  task automatic a_wait_bc(input int target, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while ((a_bc - a_off) != target && cyc < 2000);
    if ((a_bc - a_off) != target) timeout("a_wait_bc");
  endtask

  task automatic a_wait_idle();
    int cyc = 0;
    while (a_busy && cyc < 2000) begin @(negedge clk); cyc++; end
    if (a_busy) timeout("a_wait_idle");
  endtask

  task automatic b_wait_valid(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!b_valid && cyc < 2000);
    if (!b_valid) timeout("b_wait_valid");
  endtask

  task automatic b_wait_bc(input int target, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while ((b_bc - b_off) != target && cyc < 2000);
    if ((b_bc - b_off) != target) timeout("b_wait_bc");
  endtask

  task automatic b_wait_idle();
    int cyc = 0;
    while (b_busy && cyc < 2000) begin @(negedge clk); cyc++; end
    if (b_busy) timeout("b_wait_idle");
  endtask

  initial begin
    int c1, c2, n0;

    a_tbl[0] = '{32'hA5A50001, 32'h12345678, 256};
    a_tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 256};
    a_tbl[2] = '{32'h80000001, 32'h7FFFFFFE, 256};
    a_tbl[3] = '{32'hDEADBEEF, 32'hC0FFEE00, 256};
    a_tbl[4] = '{32'h0000FFFF, 32'hFFFF0000, 256};
    a_tbl[5] = '{32'h13579BDF, 32'h2468ACE0, 256};
    a_tbl[6] = '{32'h55555555, 32'hAAAAAAAA, 256};
    a_tbl[7] = '{32'hCAFEF00D, 32'h0BADC0DE, 256};
    b_tbl[0] = '{32'h0000BEEF, 32'h00000F0F, 191};
    b_tbl[1] = '{32'h00001234, 32'h00008001, 192};

    rst = 1'b1;
    a_en = 1'b0; a_ready = 1'b1; a_clr = 1'b0;
    b_en = 1'b0; b_ready = 1'b1; b_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck",   64'(a_sck),   0);
    check("rst_ws",    64'(a_ws),    0);
    check("rst_left",  64'(a_left),  0);
    check("rst_right", 64'(a_right), 0);
    check("rst_valid", 64'(a_valid), 0);
    check("rst_busy",  64'(a_busy),  0);
    check("rst_ovr",   64'(a_ovr),   0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_sck", 64'(a_sck), 0);

    // Four back-to-back frames, en dropped at k=10 of the last one
    n0 = a_ws_n;
    a_start(0);
    for (int f = 0; f < 4; f++) begin
      c1 = 0;
      if (f == 3) begin
        a_wait_bc(64 * 3 + 10, c1);
        a_en = 1'b0;
      end
      a_wait_valid(c2);
      check($sformatf("a_lat%0d", f),   64'(c1 + c2), 64'(a_tbl[f].lat));
      check($sformatf("a_left%0d", f),  64'(a_left),  64'(a_tbl[f].l));
      check($sformatf("a_right%0d", f), 64'(a_right), 64'(a_tbl[f].r));
    end
    check("stop_busy_hold", 64'(a_busy), 1);
    check("stop_sck_hold",  64'(a_sck),  1);
    @(negedge clk);
    check("stop_busy", 64'(a_busy),  0);
    check("stop_sck",  64'(a_sck),   0);
    check("stop_ws",   64'(a_ws),    0);
    check("valid_drop", 64'(a_valid), 0);
    check("stop_rises", 64'(a_ws_n - n0), 256);
    check("a_ws_err", 64'(a_ws_err), 0);

    // Backpressure across two frames
    a_ready = 1'b0;
    a_start(4);
    a_wait_valid(c2);
    check("bp_lat", 64'(c2), 256);
    a_wait_bc(64 + 10, c1);
    a_en = 1'b0;
    check("bp_ovr_pre", 64'(a_ovr), 0);
    a_wait_idle();
    check("bp_ovr",   64'(a_ovr),   1);
    check("bp_valid", 64'(a_valid), 1);
    check("bp_left",  64'(a_left),  64'(a_tbl[4].l));
    check("bp_right", 64'(a_right), 64'(a_tbl[4].r));
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("bp_ovr_clr", 64'(a_ovr), 0);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    check("bp_drain", 64'(a_valid), 0);
    check("bp_keep",  64'(a_left),  64'(a_tbl[4].l));

    // Frame completes in the same cycle as a transfer
    a_start(6);
    a_wait_valid(c2);
    check("sim_left0", 64'(a_left), 64'(a_tbl[6].l));
    a_wait_bc(64 + 10, c1);
    a_en = 1'b0;
    a_wait_bc(128, c1);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    check("sim_valid", 64'(a_valid), 1);
    check("sim_left",  64'(a_left),  64'(a_tbl[7].l));
    check("sim_right", 64'(a_right), 64'(a_tbl[7].r));
    check("sim_ovr",   64'(a_ovr),   0);
    a_wait_idle();

    // Overrun coinciding with ovr_clr_i: set wins
    a_start(0);
    a_wait_bc(10, c1);
    a_en = 1'b0;
    a_wait_bc(64, c1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("clr_vs_set", 64'(a_ovr),   1);
    check("clr_keep",   64'(a_left),  64'(a_tbl[7].l));
    check("clr_valid",  64'(a_valid), 1);
    a_wait_idle();
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    a_ready = 1'b1;
    @(negedge clk);
    check("clr_ovr",   64'(a_ovr),   0);
    check("clr_drain", 64'(a_valid), 0);

    // Reset mid-frame, then a clean restart
    a_start(1);
    a_wait_bc(40, c1);
    check("pre_rst_busy", 64'(a_busy), 1);
    rst = 1'b1;
    a_en = 1'b0;
    #1;
    check("arst_sck",   64'(a_sck),   0);
    check("arst_ws",    64'(a_ws),    0);
    check("arst_left",  64'(a_left),  0);
    check("arst_right", 64'(a_right), 0);
    check("arst_valid", 64'(a_valid), 0);
    check("arst_busy",  64'(a_busy),  0);
    check("arst_ovr",   64'(a_ovr),   0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_start(1);
    a_wait_bc(10, c1);
    a_en = 1'b0;
    a_wait_valid(c2);
    check("rst_re_lat",   64'(c1 + c2), 256);
    check("rst_re_left",  64'(a_left),  64'(a_tbl[1].l));
    check("rst_re_right", 64'(a_right), 64'(a_tbl[1].r));
    a_wait_idle();
    check("a_ws_err_end", 64'(a_ws_err), 0);

    // 16-bit words at DIV=3
    n0 = b_ws_n;
    b_start(0);
    for (int f = 0; f < 2; f++) begin
      c1 = 0;
      if (f == 1) begin
        b_wait_bc(32 + 5, c1);
        b_en = 1'b0;
      end
      b_wait_valid(c2);
      check($sformatf("b_lat%0d", f),   64'(c1 + c2), 64'(b_tbl[f].lat));
      check($sformatf("b_left%0d", f),  64'(b_left),  64'(b_tbl[f].l));
      check($sformatf("b_right%0d", f), 64'(b_right), 64'(b_tbl[f].r));
    end
    b_wait_idle();
    check("b_sck_idle", 64'(b_sck), 0);
    check("b_ws_idle",  64'(b_ws),  0);
    check("b_rises",    64'(b_ws_n - n0), 64);
    check("b_ws_err",   64'(b_ws_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
